// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the small-footprint ALU arithmetic path:
//                FSM state encoding of the serial adder, op-select constants,
//                and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the serial adder
    localparam int ALU_DEFAULT_WIDTH = 8;

    // Operation select carried on i_sub
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Serial adder sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/serial_fa_slice.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fa_slice
//  Description : Purely combinational 1-bit full adder. Holds no state, so the
//                parent owns the carry register and the slice stays reusable.
//  Ports       : a_i, b_i, cin_i -> addend bits and carry-in
//                s_o             -> sum bit
//                cout_o          -> carry-out (majority of the three inputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : serial_fa_slice
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit add/subtract sequencer. Operands are
//                accepted over a valid/ready handshake, walked LSB-first through
//                one full-adder slice with a registered carry, and the assembled
//                sum plus carry/overflow/zero flags are presented over a second
//                valid/ready handshake. Latency is WIDTH cycles of BUSY.
//  Ports       : i_clk, i_reset_n    clock, synchronous active-low reset
//                i_valid / o_ready   operand handshake (ready only in IDLE)
//                i_a, i_b, i_sub     operands, 0 = A+B, 1 = A-B
//                i_carry             carry-in (only with SERIAL_ADDER_CARRY_IN_EN)
//                o_valid / i_ready   result handshake
//                o_sum, o_carry, o_overflow, o_zero   registered result/flags
//  Config      : `define SERIAL_ADDER_CARRY_IN_EN adds i_carry; initial carry
//                becomes i_carry ^ i_sub (ADC/SBC chaining).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
`ifdef SERIAL_ADDER_CARRY_IN_EN
    input  logic             i_carry,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               fa_s;
    logic               fa_cout;
    logic               cin0;
    logic               do_sub;
    logic [WIDTH-1:0]   res_next;

    assign do_sub = (i_sub == OP_SUB);

`ifdef SERIAL_ADDER_CARRY_IN_EN
    // In SBC mode i_carry = 1 means "no borrow-in", hence the XOR.
    assign cin0 = i_carry ^ do_sub;
`else
    assign cin0 = do_sub;
`endif

    serial_fa_slice u_fa (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    // Sum bits enter at the MSB and walk right, so after WIDTH steps bit 0
    // of the result lines up with bit 0 of the operands.
    assign res_next = {fa_s, res_q[WIDTH-1:1]};

    // Ready is gated by reset so it reads low for the whole reset assertion.
    assign o_ready    = (state_q == IDLE) && i_reset_n;
    assign o_valid    = (state_q == DONE);
    assign o_sum      = sum_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    a_d     = i_a;
                    b_d     = i_b ^ {WIDTH{do_sub}};
                    carry_d = cin0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB, fa_cout the carry out.
                    sum_d   = res_next;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    zero_d  = (res_next == '0);
                    state_d = DONE;
                end
            end

            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed self-checking bench for serial_adder at WIDTH = 8.
//                Inputs change #1 after a rising edge; outputs are sampled at
//                the same point, i.e. they reflect the state after that edge.
//                The accept edge is edge 0; o_valid is seen high after edge
//                WIDTH (during the cycle whose closing edge, WIDTH+1, is the
//                hand-off), and the next accept can happen on edge WIDTH+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 50;

    logic             i_clk = 1'b0;
    logic             i_reset_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
`ifdef SERIAL_ADDER_CARRY_IN_EN
    logic             i_carry;
`endif
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_sub      (i_sub),
`ifdef SERIAL_ADDER_CARRY_IN_EN
        .i_carry    (i_carry),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Presents operands for exactly one edge; returns just after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until o_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < TIMEOUT) begin
            tick();
            n++;
        end
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({o_valid, o_ready, o_sum, o_carry, o_overflow, o_zero} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b ready=%b sum=%h c=%b v=%b z=%b, want all 0",
                     o_valid, o_ready, o_sum, o_carry, o_overflow, o_zero);
        end
        i_reset_n = 1'b1;
        tick();
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_add_sub();
        // {a, b, sub, sum, carry, overflow, zero}
        logic [WIDTH-1:0] va   [6] = '{8'h05, 8'hFF, 8'h7F, 8'h03, 8'h05, 8'h80};
        logic [WIDTH-1:0] vb   [6] = '{8'h03, 8'h01, 8'h01, 8'h05, 8'h05, 8'h01};
        logic             vs   [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [WIDTH-1:0] esum [6] = '{8'h08, 8'h00, 8'h80, 8'hFE, 8'h00, 8'h7F};
        logic             ec   [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        logic             ev   [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        logic             ez   [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        int n;
        for (int i = 0; i < 6; i++) begin
            start_op(va[i], vb[i], vs[i]);
            // i_sub toggled during BUSY must not affect the result
            i_sub = ~vs[i];
            n_cmp++;
            if (o_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_ready[%0d]: got %b want 0", i, o_ready);
            end
            wait_valid(n);
            n_cmp++;
            if (n !== WIDTH) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d edges want %0d", i, n, WIDTH);
            end
            n_cmp++;
            if ({o_sum, o_carry, o_overflow, o_zero} !== {esum[i], ec[i], ev[i], ez[i]}) begin
                n_bad++;
                $display("FAIL result[%0d]: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                         i, o_sum, o_carry, o_overflow, o_zero, esum[i], ec[i], ev[i], ez[i]);
            end
            tick();
            n_cmp++;
            if ({o_valid, o_ready} !== 2'b01) begin
                n_bad++;
                $display("FAIL handoff[%0d]: got valid=%b ready=%b want valid=0 ready=1",
                         i, o_valid, o_ready);
            end
        end
    endtask

    // Enters reset at BUSY cycle 4; the previous op (0x80-0x01) left
    // sum=7F carry=1 overflow=1 so the clear is observable.
    task automatic test_reset_abort();
        int  n;
        logic seen;
        start_op(8'h77, 8'h11, 1'b0);
        repeat (4) tick();
        i_reset_n = 1'b0;
        tick();
        n_cmp++;
        if ({o_valid, o_ready, o_sum, o_carry, o_overflow, o_zero} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got valid=%b ready=%b sum=%h c=%b v=%b z=%b, want all 0",
                     o_valid, o_ready, o_sum, o_carry, o_overflow, o_zero);
        end
        i_reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (o_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_partial: got valid seen=%b want 0", seen);
        end
`ifdef SERIAL_ADDER_CARRY_IN_EN
        i_carry = 1'b1;
`endif
        start_op(8'h10, 8'h20, 1'b0);
`ifdef SERIAL_ADDER_CARRY_IN_EN
        i_carry = 1'b0;
`endif
        wait_valid(n);
        n_cmp++;
`ifdef SERIAL_ADDER_CARRY_IN_EN
        if (n !== WIDTH || {o_sum, o_carry, o_overflow, o_zero} !== {8'h31, 3'b000}) begin
            n_bad++;
            $display("FAIL post_reset_op: got n=%0d sum=%h c=%b v=%b z=%b want n=%0d sum=31 c=0 v=0 z=0",
                     n, o_sum, o_carry, o_overflow, o_zero, WIDTH);
        end
`else
        if (n !== WIDTH || {o_sum, o_carry, o_overflow, o_zero} !== {8'h30, 3'b000}) begin
            n_bad++;
            $display("FAIL post_reset_op: got n=%0d sum=%h c=%b v=%b z=%b want n=%0d sum=30 c=0 v=0 z=0",
                     n, o_sum, o_carry, o_overflow, o_zero, WIDTH);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int   n;
        logic bad;
        i_ready = 1'b0;
        start_op(8'h12, 8'h34, 1'b0);
        wait_valid(n);
        n_cmp++;
        if (n !== WIDTH || o_sum !== 8'h46) begin
            n_bad++;
            $display("FAIL bp_result: got n=%0d sum=%h want n=%0d sum=46", n, o_sum, WIDTH);
        end
        bad = 1'b0;
        i_a     = 8'hAA;
        i_b     = 8'h55;
        for (int k = 0; k < 5; k++) begin
            i_valid = k[0] ? 1'b0 : 1'b1;
            tick();
            if ({o_valid, o_ready, o_sum} !== {2'b10, 8'h46}) bad = 1'b1;
        end
        i_valid = 1'b0;
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold: got valid=%b ready=%b sum=%h want valid=1 ready=0 sum=46",
                     o_valid, o_ready, o_sum);
        end
        i_ready = 1'b1;
        tick();
        n_cmp++;
        if ({o_valid, o_ready, o_sum} !== {2'b01, 8'h46}) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b ready=%b sum=%h want valid=0 ready=1 sum=46",
                     o_valid, o_ready, o_sum);
        end
        // If the pulsed operands had been taken, the block would now be busy.
        tick();
        tick();
        n_cmp++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_not_accepted: got valid=%b ready=%b want valid=0 ready=1",
                     o_valid, o_ready);
        end
    endtask

    // Second op accepted on the first IDLE cycle: interval WIDTH+2 edges.
    task automatic test_back_to_back();
        int n;
        start_op(8'h01, 8'h01, 1'b0);
        wait_valid(n);
        n_cmp++;
        if (n !== WIDTH || {o_sum, o_carry, o_overflow, o_zero} !== {8'h02, 3'b000}) begin
            n_bad++;
            $display("FAIL b2b_first: got n=%0d sum=%h c=%b v=%b z=%b want n=%0d sum=02 flags=000",
                     n, o_sum, o_carry, o_overflow, o_zero, WIDTH);
        end
        tick();
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got %b want 1", o_ready);
        end
        start_op(8'h00, 8'h01, 1'b1);
        wait_valid(n);
        n_cmp++;
        if (n !== WIDTH || {o_sum, o_carry, o_overflow, o_zero} !== {8'hFF, 3'b000}) begin
            n_bad++;
            $display("FAIL b2b_second: got n=%0d sum=%h c=%b v=%b z=%b want n=%0d sum=FF flags=000",
                     n, o_sum, o_carry, o_overflow, o_zero, WIDTH);
        end
        tick();
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_a       = '0;
        i_b       = '0;
        i_sub     = 1'b0;
`ifdef SERIAL_ADDER_CARRY_IN_EN
        i_carry   = 1'b0;
`endif
        tick();
        test_reset();
        test_add_sub();
        test_reset_abort();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit add/subtract sequencer for the ALU arithmetic path.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Walks them LSB-first through a one-bit full-adder slice with a registered carry, then presents the assembled sum and flags over a valid/ready handshake.
- Trades latency (WIDTH cycles) for area, for the small-footprint ALU configuration.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset_n  input  1  synchronous active-low reset, sampled on rising edge of i_clk
i_valid  input  1  operands/op presented
o_ready  output  1  block can accept operands (high only in IDLE)
i_a  input  WIDTH  operand A
i_b  input  WIDTH  operand B
i_sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1)
o_valid  output  1  result available
i_ready  input  1  consumer accepts result
o_sum  output  WIDTH  result
o_carry  output  1  carry-out of MSB; for subtract, 1 = no borrow
o_overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
o_zero  output  1  o_sum == 0

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (i_reset_n low at a clock edge):
  - state <- IDLE; carry reg, bit counter, operand and result shift regs <- 0.
  - o_valid = 0, o_sum = 0, o_carry = 0, o_overflow = 0, o_zero = 0.
  - o_ready = 0 while i_reset_n is low; o_ready = 1 from the first cycle after release.
  - Reset mid-BUSY or mid-DONE aborts the operation; no partial result is ever flagged valid.
- IDLE:
  - o_ready = 1.
  - On i_valid && o_ready: latch i_a, i_b ^ {WIDTH{i_sub}}, carry <- i_sub (or carry-in, see Optional Feature), counter <- 0; go to BUSY.
- BUSY:
  - Each cycle: bit = a[0] ^ b[0] ^ carry; carry <- majority(a[0], b[0], carry).
  - Shift A and B right by 1; shift the sum bit into the result MSB (result shifts right).
  - Counter increments each cycle. The cycle that processes counter == WIDTH-1 also records carry-in-to-MSB (the carry value before the update) for overflow, then goes to DONE.
  - i_valid is ignored; o_ready = 0.
- DONE:
  - o_valid = 1; o_sum, o_carry, o_overflow, o_zero are registered and stable.
  - On i_ready: go to IDLE, o_valid = 0 next cycle. Outputs hold their last value until the next DONE; o_valid is the only qualifier.
- Timing:
  - Accept edge = cycle 0; o_valid rises at cycle WIDTH+1.
  - Minimum initiation interval is WIDTH+2, since o_ready is low in DONE. Accept and result hand-off can never coincide.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - i_sub samples only at the accept edge; changes during BUSY have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_CARRY_IN_EN.
- Defined:
  - Adds input port i_carry (1 bit), latched at the accept edge.
  - Initial carry = i_carry ^ i_sub, which gives ADC/SBC semantics for chaining multi-word operations; in SBC, i_carry = 1 means no borrow-in.
- Undefined:
  - Port absent; initial carry = i_sub.

Decomposition:
- Shared package alu_pkg: state encoding typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), the op-select constants OP_ADD/OP_SUB, and the default WIDTH constant.
- One sub-module: serial_fa_slice, a purely combinational 1-bit full adder (a, b, cin -> s, cout).
  - Instantiated once.
  - Carry register stays in the parent so the slice stays reusable and the FSM owns all state.

Test Plan (WIDTH=8):
- Add 0x05+0x03, i_sub=0, i_ready=1 -> o_valid at cycle 9; o_sum=0x08, carry=0, overflow=0, zero=0.
- Add 0xFF+0x01 -> o_sum=0x00, carry=1, zero=1, overflow=0.
- Add 0x7F+0x01 -> o_sum=0x80, overflow=1, carry=0.
- Sub 0x03-0x05 -> o_sum=0xFE, carry=0 (borrow), overflow=0; sub 0x80-0x01 -> 0x7F, carry=1, overflow=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands.
  - Required: o_valid stays 1, o_sum stays stable, o_ready stays 0, and the new operands are not accepted.
  - Release i_ready -> o_ready=1 on the following cycle.
- Drive i_reset_n=0 at BUSY cycle 4.
  - Required: next cycle all outputs 0, o_valid=0.
  - Then 0x10+0x20 -> 0x30 with correct flags. With SERIAL_ADDER_CARRY_IN_EN, 0x10+0x20 with i_carry=1 -> 0x31.
